prime_candidate_gen: RTL

PRIME_CANDIDATE_GEN -- requirements
Module: prime_candidate_gen

---
 rtl/prime_candidate_gen.sv | 120 ++++++++++++
 1 files changed

// File: rtl/prime_candidate_gen.sv
// rtl/prime_candidate_gen.sv - LFSR-driven odd candidate generator that sequences an external primality tester.
module prime_candidate_gen #(
  parameter int unsigned             WORD_WIDTH   = 32,
  parameter logic [WORD_WIDTH-1:0]   TAPS         = 32'h80200003,
  parameter logic [WORD_WIDTH-1:0]   DEFAULT_SEED = 32'hACE12468,
  parameter int unsigned             MAX_ATTEMPTS = 1000,
  parameter int unsigned             T_ROUNDS     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  seed_load,
  input  logic [WORD_WIDTH-1:0] seed,
  output logic                  mr_clear,
  output logic                  mr_enable,
  output logic [WORD_WIDTH-1:0] mr_n,
  output logic [5:0]            mr_t,
  input  logic                  mr_done,
  input  logic                  mr_is_prime,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [WORD_WIDTH-1:0] prime,
  output logic [15:0]           attempts
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_FAIL
  } state_e;

  localparam logic [WORD_WIDTH-1:0] LFSR_ONE   = {{(WORD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WORD_WIDTH-1:0] FORCE_MASK = {1'b1, {(WORD_WIDTH-2){1'b0}}, 1'b1};
  localparam logic [5:0]            MR_T       = T_ROUNDS[5:0];

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WORD_WIDTH-1:0] mr_n_q, mr_n_d;
  logic [WORD_WIDTH-1:0] prime_q, prime_d;
  logic [15:0]           attempts_q, attempts_d;
  logic [WORD_WIDTH-1:0] lfsr_step;

  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= DEFAULT_SEED;
      mr_n_q     <= '0;
      prime_q    <= '0;
      attempts_q <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      mr_n_q     <= mr_n_d;
      prime_q    <= prime_d;
      attempts_q <= attempts_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    mr_n_d     = mr_n_q;
    prime_d    = prime_q;
    attempts_d = attempts_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        // Seed lands this edge, so a simultaneous start steps from the new seed in GEN.
        if (seed_load) begin
          lfsr_d = (seed == '0) ? LFSR_ONE : seed;
        end
        if (enable) begin
          attempts_d = '0;
          state_d    = S_GEN;
        end
      end
      S_GEN: begin
        lfsr_d     = lfsr_step;
        mr_n_d     = lfsr_step | FORCE_MASK;
        attempts_d = (attempts_q == 16'hFFFF) ? attempts_q : attempts_q + 16'd1;
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mr_done) begin
          if (mr_is_prime) begin
            prime_d = mr_n_q;
            state_d = S_DONE;
          end else if ({16'd0, attempts_q} >= MAX_ATTEMPTS) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_GEN;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control outputs are pure state decodes, so reset clears them without a clock.
  assign mr_clear  = (state_q == S_GEN);
  assign mr_enable = (state_q == S_ISSUE);
  assign busy      = (state_q == S_GEN) || (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign done      = (state_q == S_DONE) || (state_q == S_FAIL);
  assign fail      = (state_q == S_FAIL);
  assign mr_n      = mr_n_q;
  assign prime     = prime_q;
  assign attempts  = attempts_q;
  assign mr_t      = MR_T;

endmodule
